// File: rtl/cache_responder.sv
// Direct-mapped, write-through, no-write-allocate cache serving the multicycle core's data port.
// One word per line; misses and all stores go to backing memory over a req/ack handshake.
//
// state  | meaning
// IDLE   | waiting for a core request (write wins if both enables are low)
// LOOKUP | tag compare on the latched address; hit reads finish here
// FILL   | read miss outstanding, waiting for mem_ack to load the line
// WRITE  | store outstanding to backing memory, waiting for mem_ack
module cache_responder #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              r_en,
  input  logic              w_en,
  output logic              stall,
  output logic [DATA_W-1:0] saida_cache,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, WRITE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_write;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  hit;
  logic                  line_we;
  logic [DATA_W-1:0]     line_wdata;

  // Everything past IDLE works from the latched request; the core's address mux moves on.
  assign idx        = req_addr[INDEX_BITS-1:0];
  assign req_tag    = req_addr[ADDR_W-1:INDEX_BITS];
  assign hit        = valid[idx] && (tag_arr[idx] == req_tag);
  assign line_we    = ((state == LOOKUP) && req_write && hit) || ((state == FILL) && mem_ack);
  assign line_wdata = (state == FILL) ? mem_rdata : req_data;

  // Line storage carries no reset; the valid bits alone decide whether a line means anything.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_arr[idx] <= line_wdata;
      if (state == FILL) tag_arr[idx] <= req_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      valid       <= '0;
      req_addr    <= '0;
      req_data    <= '0;
      req_write   <= 1'b0;
      stall       <= 1'b0;
      saida_cache <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!w_en || !r_en) begin
            req_addr  <= address;
            req_data  <= data;
            req_write <= !w_en;
            stall     <= 1'b1;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (req_write) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= req_addr;
            mem_wdata <= req_data;
            state     <= WRITE;
          end else if (hit) begin
            saida_cache <= data_arr[idx];
            stall       <= 1'b0;
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            state       <= IDLE;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= req_addr;
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            state    <= FILL;
          end
        end
        FILL: begin
          if (mem_ack) begin
            valid[idx]  <= 1'b1;
            saida_cache <= mem_rdata;
            mem_req     <= 1'b0;
            stall       <= 1'b0;
            state       <= IDLE;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            stall   <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
